// File: rtl/nth_root_if.sv
// nth_root_if: operand/result handshake bundle for nth_root_engine.
// master = operand front-end / result collector side, slave = engine side.
interface nth_root_if #(
    parameter int DIN_W  = 10,
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 3
);
    localparam int OUT_W = DIN_W + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic [DIN_W-1:0] in_data_1;
    logic [EXP_W-1:0] in_data_2;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_exact;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_data_1, in_data_2, out_ready,
        input  in_ready, out_valid, out_data, out_exact, out_err, busy
    );

    modport slave (
        input  in_valid, in_data_1, in_data_2, out_ready,
        output in_ready, out_valid, out_data, out_exact, out_err, busy
    );
endinterface

// File: rtl/nth_root_engine.sv
// nth_root_engine: bit-serial fixed-point k-th root, out = floor(x^(1/k) * 2^FRAC_W).
// One trial bit per k cycles (k-1 multiply cycles plus one compare) using a
// single shared ACC_W x ACC_W multiplier.
// Optional feature macro: ROOT_ROUND_EN -- runs one extra guard bit and rounds
// half-up, saturating at all-ones.
module nth_root_engine #(
    parameter int DIN_W  = 10,
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    nth_root_if.slave bus
);
    localparam int OUT_W = DIN_W + FRAC_W;
    localparam int K_MAX = (1 << EXP_W) - 1;
`ifdef ROOT_ROUND_EN
    localparam int RW    = OUT_W + 1;   // root carries one guard bit
    localparam int SH    = FRAC_W + 1;
`else
    localparam int RW    = OUT_W;
    localparam int SH    = FRAC_W;
`endif
    localparam int ACC_W = K_MAX * RW;  // guess^k never exceeds this

    typedef enum logic [2:0] {IDLE, LOAD, MUL, CMP, DONE} state_t;

    state_t           state, state_nxt;
    logic [EXP_W-1:0] k_q;
    logic [EXP_W-1:0] mul_cnt;
    logic [ACC_W-1:0] tgt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;
    logic [RW-1:0]    root;
    logic [RW-1:0]    base;
    logic [RW-1:0]    guess;
    logic [RW-1:0]    root_nxt;
    logic             acc_gt;
    logic             acc_eq;
    logic             cmp_done;
    logic             accept;
    logic             k_is_one;
    logic [OUT_W-1:0] out_data_q;
    logic             out_exact_q;
    logic             out_err_q;

    // Converts the internal root to the output format (guard-bit rounding when enabled).
    function automatic logic [OUT_W-1:0] finish_root(input logic [RW-1:0] r);
`ifdef ROOT_ROUND_EN
        logic [RW:0] sum;
        sum = {1'b0, r} + {{RW{1'b0}}, 1'b1};
        if (sum[RW])
            return '1;
        return sum[RW-1:1];
`else
        return r;
`endif
    endfunction

    assign accept   = bus.in_valid && (state == IDLE);
    assign k_is_one = (k_q == EXP_W'(1));
    assign guess    = root | base;
    assign prod     = acc * ACC_W'(guess);
    assign acc_gt   = (acc > tgt);
    assign acc_eq   = (acc == tgt);
    assign root_nxt = acc_gt ? root : guess;
    assign cmp_done = acc_eq || base[0];

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == LOAD) || (state == MUL) || (state == CMP);
    assign bus.out_data  = out_data_q;
    assign bus.out_exact = out_exact_q;
    assign bus.out_err   = out_err_q;

    // State register; reset abandons any calculation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: k==0 bypasses the calculation, k==1 needs no multiply cycles,
    // a partial power already above the target aborts straight to compare.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (bus.in_data_2 == '0) ? DONE : LOAD;
            LOAD: state_nxt = k_is_one ? CMP : MUL;
            MUL:  if (mul_cnt == EXP_W'(1) || prod > tgt) state_nxt = CMP;
            CMP:  begin
                if (cmp_done)
                    state_nxt = DONE;
                else
                    state_nxt = k_is_one ? CMP : MUL;
            end
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: target latch, trial-bit setup, repeated multiply and root update.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    k_q <= bus.in_data_2;
                    tgt <= ACC_W'(bus.in_data_1) << (SH * int'(bus.in_data_2));
                end
            end
            LOAD: begin
                root    <= '0;
                base    <= {1'b1, {(RW-1){1'b0}}};
                acc     <= ACC_W'({1'b1, {(RW-1){1'b0}}});
                mul_cnt <= k_q - EXP_W'(1);
            end
            MUL: begin
                acc     <= prod;
                mul_cnt <= mul_cnt - EXP_W'(1);
            end
            CMP: begin
                root    <= root_nxt;
                base    <= base >> 1;
                acc     <= ACC_W'(root_nxt | (base >> 1));
                mul_cnt <= k_q - EXP_W'(1);
            end
            default: ;
        endcase
    end

    // Result registers: cleared on accept, loaded when the last compare resolves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_exact_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_data_q  <= '0;
            out_exact_q <= 1'b0;
            out_err_q   <= (bus.in_data_2 == '0);
        end else if (state == CMP && cmp_done) begin
            out_data_q  <= finish_root(root_nxt);
            out_exact_q <= acc_eq;
        end
    end
endmodule
